scramble_byte_serializer: RTL and testbench

SCRAMBLE_BYTE_SERIALIZER -- requirements
Module: scramble_byte_serializer

---
 rtl/scramble_byte_serializer.sv | 120 ++++++++++++
 tb/tb_scramble_byte_serializer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/scramble_byte_serializer.sv
// Word-to-byte serializer: buffers 32-bit scrambled words in a small FIFO
// and emits them MSB byte first on a ready/valid byte stream.
module scramble_byte_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              din,
    input  logic                     pushin,
    output logic [7:0]               byte_out,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic                     idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state, state_nx;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [31:0]     hold;
    logic [1:0]      idx;
    logic            fifo_empty;
    logic            push_ok;
    logic            pop;
    logic            last_taken;

    // FIFO status; full comes from the registered level so a same-cycle pop
    // never makes room for an incoming word.
    always_comb begin
        fifo_empty = (level == '0);
        full       = (level == LW'(DEPTH));
        push_ok    = pushin && !full;
        idle       = (state == IDLE) && fifo_empty;
        last_taken = (state == SEND) && byte_ready && (idx == 2'd3);
    end

    // Next-state, pop request and byte output selection.
    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        byte_valid = 1'b0;
        byte_out   = '0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                byte_valid = 1'b1;
                case (idx)
                    2'd0:    byte_out = hold[31:24];
                    2'd1:    byte_out = hold[23:16];
                    2'd2:    byte_out = hold[15:8];
                    default: byte_out = hold[7:0];
                endcase
                if (last_taken) begin
                    if (!fifo_empty) pop = 1'b1;
                    else             state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Hold register and byte index: load on pop, advance on accepted byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
            idx  <= '0;
        end else if (pop) begin
            hold <= mem[rd_ptr];
            idx  <= '0;
        end else if ((state == SEND) && byte_ready && (idx != 2'd3)) begin
            idx <= idx + 2'd1;
        end
    end

    // FIFO storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr] <= din;
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)        wr_ptr   <= wr_ptr + 1'b1;
            if (pop)            rd_ptr   <= rd_ptr + 1'b1;
            if (pushin && full) overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_scramble_byte_serializer.sv
// Randomized bench for scramble_byte_serializer against a queue-based
// reference model of the word buffer and outgoing byte stream.
module tb_scramble_byte_serializer;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic [31:0]   din;
    logic          pushin;
    logic [7:0]    byte_out;
    logic          byte_valid;
    logic          byte_ready;
    logic [LW-1:0] level;
    logic          full;
    logic          overflow;
    logic          idle;

    int n_checks;
    int n_pass;

    // Reference model: buffered words, and bytes of the word being sent.
    logic [31:0] fifo_q [$];
    logic [7:0]  cur_q  [$];
    logic        m_ovf;

    scramble_byte_serializer #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .pushin     (pushin),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .level      (level),
        .full       (full),
        .overflow   (overflow),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_edge();
        logic        was_full;
        logic [31:0] w;
        if (rst) begin
            fifo_q.delete();
            cur_q.delete();
            m_ovf = 1'b0;
            return;
        end
        was_full = (fifo_q.size() == DEPTH);
        if (cur_q.size() > 0 && byte_ready) void'(cur_q.pop_front());
        if (cur_q.size() == 0 && fifo_q.size() > 0) begin
            w = fifo_q.pop_front();
            for (int i = 0; i < 4; i++) cur_q.push_back(w[31-8*i -: 8]);
        end
        if (pushin) begin
            if (was_full) m_ovf = 1'b1;
            else          fifo_q.push_back(din);
        end
    endtask

    task automatic compare_all();
        check("byte_valid", 32'(byte_valid), 32'(cur_q.size() > 0));
        check("byte_out",   32'(byte_out),   (cur_q.size() > 0) ? 32'(cur_q[0]) : 32'h0);
        check("level",      32'(level),      32'(fifo_q.size()));
        check("full",       32'(full),       32'(fifo_q.size() == DEPTH));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("idle",       32'(idle),       32'(cur_q.size() == 0 && fifo_q.size() == 0));
    endtask

    task automatic step(input logic p, input logic [31:0] d, input logic r, input logic rs);
        pushin     = p;
        din        = d;
        byte_ready = r;
        rst        = rs;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_steps(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, r, 1'b0);
    endtask

    initial begin
        int gap;
        n_checks   = 0;
        n_pass     = 0;
        m_ovf      = 1'b0;
        rst        = 1'b1;
        pushin     = 1'b0;
        din        = '0;
        byte_ready = 1'b0;

        // Reset, with a push attempted during reset that must be ignored.
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'hCAFEF00D, 1'b1, 1'b1);
        check("rst_idle",  32'(idle), 32'h1);
        check("rst_level", 32'(level), 32'h0);
        idle_steps(2, 1'b1);

        // Single word, MSB byte first, two cycles after the push.
        step(1'b1, 32'hA1B2C3D4, 1'b1, 1'b0);
        check("lat_not_yet", 32'(byte_valid), 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("lat_first", 32'(byte_out), 32'hA1);
        idle_steps(5, 1'b1);
        check("single_idle", 32'(idle), 32'h1);

        // Back-pressure holds the first byte stable.
        step(1'b1, 32'h11223344, 1'b0, 1'b0);
        idle_steps(6, 1'b0);
        check("bp_hold", 32'(byte_out), 32'h11);
        idle_steps(6, 1'b1);

        // Three back-to-back words give twelve contiguous bytes.
        step(1'b1, 32'h01020304, 1'b1, 1'b0);
        step(1'b1, 32'h05060708, 1'b1, 1'b0);
        step(1'b1, 32'h090A0B0C, 1'b1, 1'b0);
        idle_steps(14, 1'b1);

        // Overflow: six pushes with the sink stalled.
        for (int i = 0; i < 6; i++) step(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0);
        check("ovf_level", 32'(level), 32'h4);
        check("ovf_full",  32'(full), 32'h1);
        check("ovf_flag",  32'(overflow), 32'h1);
        idle_steps(24, 1'b1);
        check("ovf_sticky", 32'(overflow), 32'h1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("ovf_cleared", 32'(overflow), 32'h0);

        // Reset while the second byte of a word is on the output.
        step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("mid_second", 32'(byte_out), 32'hAD);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        check("mid_valid", 32'(byte_valid), 32'h0);
        check("mid_idle",  32'(idle), 32'h1);
        idle_steps(8, 1'b1);

        // Twenty random words spaced four or more cycles, random sink readiness.
        for (int w = 0; w < 20; w++) begin
            step(1'b1, $urandom, ($urandom_range(0, 3) != 0), 1'b0);
            gap = $urandom_range(3, 6);
            for (int g = 0; g < gap; g++) step(1'b0, $urandom, 1'b1, 1'b0);
        end
        idle_steps(10, 1'b1);
        check("wrap_no_ovf", 32'(overflow), 32'h0);

        // Fully random traffic including occasional resets.
        for (int c = 0; c < 400; c++)
            step(($urandom_range(0, 2) == 0), $urandom, ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) == 0));
        idle_steps(30, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
